// File: rtl/float_add_sub_seq_if.sv
// Operand/result bundle for the sequential float adder/subtractor.
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// ready=1; alpha, beta and op are sampled on that edge only. ready is high
// while the unit is idle or holding a finished result. valid is high only
// while a finished result is held; result, overflow and underflow are
// meaningful only when valid=1 and stay stable until the next accepted start.
interface float_add_sub_seq_if #(
   parameter int EXP_WIDTH  = 4,
   parameter int MANT_WIDTH = 3
);
   localparam int W = 1 + EXP_WIDTH + MANT_WIDTH;

   logic         start;
   logic         op;
   logic [W-1:0] alpha;
   logic [W-1:0] beta;
   logic         ready;
   logic         valid;
   logic [W-1:0] result;
   logic         overflow;
   logic         underflow;

   modport master (
      output start, op, alpha, beta,
      input  ready, valid, result, overflow, underflow
   );

   modport slave (
      input  start, op, alpha, beta,
      output ready, valid, result, overflow, underflow
   );
endinterface

// File: rtl/float_add_sub_seq.sv
// Multi-cycle floating-point adder/subtractor: capture, align, add,
// normalise (one shift per cycle), round to nearest even, then hold.
module float_add_sub_seq #(
   parameter int EXP_WIDTH  = 4,
   parameter int MANT_WIDTH = 3,
   parameter int BIAS       = 7
) (
   input  logic                clock,
   input  logic                clear,
   float_add_sub_seq_if.slave  bus,
   output logic [2:0]          dbg_state_o
);
   localparam int W   = 1 + EXP_WIDTH + MANT_WIDTH;
   localparam int MW  = MANT_WIDTH + 5;  // {carry, hidden, mant, guard, round, sticky}
   localparam int EW  = EXP_WIDTH + 2;   // signed working exponent
   localparam int SHW = MANT_WIDTH + 3;  // shift distance that leaves only sticky

   localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ALIGN = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_NORM  = 3'd3;
   localparam logic [2:0] S_ROUND = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // The bias only shifts the meaning of the exponent field; addition itself
   // works on raw fields, so it is only range-checked here.
   if (BIAS < 1 || BIAS >= (1 << EXP_WIDTH) - 1) begin : g_bias_check
      $error("float_add_sub_seq: BIAS out of range for EXP_WIDTH");
   end

   logic [2:0]                state_q, state_d;
   logic                      sign_gt_q, sign_gt_d, sign_lt_q, sign_lt_d;
   logic [EXP_WIDTH-1:0]      exp_gt_q, exp_gt_d, exp_lt_q, exp_lt_d;
   logic [MW-1:0]             mant_gt_q, mant_gt_d, mant_lt_q, mant_lt_d;
   logic                      sign_q, sign_d;
   logic signed [EW-1:0]      exp_q, exp_d;
   logic [MW-1:0]             mant_q, mant_d;
   logic [W-1:0]              result_q, result_d;
   logic                      ovf_q, ovf_d, unf_q, unf_d;

   logic                      ready, accept;
   logic [EXP_WIDTH-1:0]      a_exp, b_exp, diff;
   logic [MANT_WIDTH-1:0]     a_man, b_man, frac;
   logic                      b_sign, round_up;
   logic [MW-1:0]             a_ext, b_ext, shifted, lost_mask;
   logic [MANT_WIDTH+1:0]     sig;
   logic signed [EW-1:0]      exp_r;

   assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept = bus.start && ready;

   // Operand decode: a zero exponent field means zero, mantissa ignored.
   always_comb begin
      a_exp  = bus.alpha[W-2:MANT_WIDTH];
      b_exp  = bus.beta[W-2:MANT_WIDTH];
      a_man  = (a_exp != '0) ? bus.alpha[MANT_WIDTH-1:0] : '0;
      b_man  = (b_exp != '0) ? bus.beta[MANT_WIDTH-1:0]  : '0;
      b_sign = bus.beta[W-1] ^ bus.op;
      a_ext  = {1'b0, (a_exp != '0), a_man, 3'b000};
      b_ext  = {1'b0, (b_exp != '0), b_man, 3'b000};
   end

   // Next-state logic for the whole datapath, one FSM step per cycle.
   always_comb begin
      state_d   = state_q;
      sign_gt_d = sign_gt_q;
      sign_lt_d = sign_lt_q;
      exp_gt_d  = exp_gt_q;
      exp_lt_d  = exp_lt_q;
      mant_gt_d = mant_gt_q;
      mant_lt_d = mant_lt_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      diff      = exp_gt_q - exp_lt_q;
      lost_mask = ~({MW{1'b1}} << diff);
      shifted   = (mant_lt_q >> diff) | {{(MW-1){1'b0}}, |(mant_lt_q & lost_mask)};
      round_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
      sig       = {1'b0, mant_q[MW-2:3]} + {{(MANT_WIDTH+1){1'b0}}, round_up};
      frac      = sig[MANT_WIDTH+1] ? sig[MANT_WIDTH:1] : sig[MANT_WIDTH-1:0];
      exp_r     = sig[MANT_WIDTH+1] ? exp_q + EXP_ONE : exp_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = S_ALIGN;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               if ({a_exp, a_man} >= {b_exp, b_man}) begin
                  sign_gt_d = bus.alpha[W-1]; exp_gt_d = a_exp; mant_gt_d = a_ext;
                  sign_lt_d = b_sign;         exp_lt_d = b_exp; mant_lt_d = b_ext;
               end else begin
                  sign_gt_d = b_sign;         exp_gt_d = b_exp; mant_gt_d = b_ext;
                  sign_lt_d = bus.alpha[W-1]; exp_lt_d = a_exp; mant_lt_d = a_ext;
               end
            end
         end
         S_ALIGN: begin
            state_d   = S_ADD;
            mant_lt_d = (int'(diff) >= SHW) ? {{(MW-1){1'b0}}, |mant_lt_q} : shifted;
         end
         S_ADD: begin
            state_d = S_NORM;
            mant_d  = (sign_gt_q == sign_lt_q) ? mant_gt_q + mant_lt_q
                                               : mant_gt_q - mant_lt_q;
            sign_d  = sign_gt_q;
            exp_d   = $signed({2'b00, exp_gt_q});
         end
         S_NORM: begin
            if (mant_q == '0) begin
               sign_d  = 1'b0;
               state_d = S_ROUND;
            end else if (mant_q[MW-1]) begin
               mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
               exp_d  = exp_q + EXP_ONE;
            end else if (!mant_q[MW-2]) begin
               mant_d = {mant_q[MW-2:0], 1'b0};
               exp_d  = exp_q - EXP_ONE;
            end else begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            state_d = S_DONE;
            if (mant_q == '0) begin
               result_d = '0;
            end else if (exp_r > EXP_MAX) begin
               result_d = {sign_q, {(W-1){1'b1}}};
               ovf_d    = 1'b1;
            end else if (exp_r < EXP_ONE) begin
               result_d = {sign_q, {(W-1){1'b0}}};
               unf_d    = 1'b1;
            end else begin
               result_d = {sign_q, exp_r[EXP_WIDTH-1:0], frac};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; clear wins over any request.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= S_IDLE;
         sign_gt_q <= 1'b0;
         sign_lt_q <= 1'b0;
         exp_gt_q  <= '0;
         exp_lt_q  <= '0;
         mant_gt_q <= '0;
         mant_lt_q <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_gt_q <= sign_gt_d;
         sign_lt_q <= sign_lt_d;
         exp_gt_q  <= exp_gt_d;
         exp_lt_q  <= exp_lt_d;
         mant_gt_q <= mant_gt_d;
         mant_lt_q <= mant_lt_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign bus.ready     = ready;
   assign bus.valid     = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_float_add_sub_seq.sv
// Bench for float_add_sub_seq: directed vector table, control sequences,
// and random operands checked against an exact-arithmetic reference model.
module tb_float_add_sub_seq;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         op;
      logic [W-1:0] res;
      logic         ovf;
      logic         unf;
      int           lat;
   } vec_t;

   logic       clock;
   logic       clear;
   logic [2:0] dbg_state;
   logic [2:0] idle_state;
   int         n_checks;
   int         n_pass;
   logic [W+1:0] exp_q[$];

   float_add_sub_seq_if #(.EXP_WIDTH(4), .MANT_WIDTH(3)) bus ();

   float_add_sub_seq #(.EXP_WIDTH(4), .MANT_WIDTH(3), .BIAS(7)) dut (
      .clock       (clock),
      .clear       (clear),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Reference: exact value as an integer in units of 2^-9 (smallest ulp),
   // exact sum, then round to 4 significant bits with ties to even.
   function automatic longint fval(input logic [W-1:0] x);
      longint mag;
      if (x[6:3] == 4'd0) return 0;
      mag = longint'(8 + x[2:0]) << (x[6:3] - 1);
      return x[7] ? -mag : mag;
   endfunction

   function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic op);
      longint s, mag, q, rem, half;
      int     p, sh, e;
      logic   sgn;
      s = fval(a) + (op ? -fval(b) : fval(b));
      if (s == 0) return '0;
      sgn = (s < 0);
      mag = sgn ? -s : s;
      p = 0;
      for (int i = 0; i < 40; i++) if (mag >= (64'sd1 <<< i)) p = i;
      if (p >= 3) begin
         sh  = p - 3;
         q   = mag >>> sh;
         rem = mag - (q <<< sh);
         if (sh > 0) begin
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
         end
         if (q == 16) begin
            q = 8;
            p++;
         end
      end else begin
         q = mag <<< (3 - p);
      end
      e = p - 2;
      if (e > 15) return {1'b1, 1'b0, sgn, 7'h7F};
      if (e < 1)  return {1'b0, 1'b1, sgn, 7'h00};
      return {1'b0, 1'b0, sgn, e[3:0], q[2:0]};
   endfunction

   // Driver: one request, then wait (bounded) for valid; lat = edges after accept.
   task automatic run_op(input logic [W-1:0] a, b, input logic o,
                         output logic [W-1:0] res, output logic ovf, unf, output int lat);
      int guard;
      guard = 0;
      @(negedge clock);
      while (!bus.ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      check("ready_before_start", 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.alpha = a;
      bus.beta  = b;
      bus.op    = o;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.alpha = $urandom_range(0, 255);
      bus.beta  = $urandom_range(0, 255);
      bus.op    = $urandom_range(0, 1);
      check("accept_drops_valid_flags", {29'd0, bus.valid, bus.overflow, bus.underflow}, 32'd0);
      lat = 0;
      while (!bus.valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      res = bus.result;
      ovf = bus.overflow;
      unf = bus.underflow;
   endtask

   initial begin
      vec_t         vecs[9];
      logic [W-1:0] res;
      logic         ovf, unf;
      int           lat;
      logic [W+1:0] e;

      n_checks = 0;
      n_pass   = 0;
      vecs[0] = '{8'h38, 8'h38, 1'b0, 8'h40, 1'b0, 1'b0, 5};
      vecs[1] = '{8'h3C, 8'h3A, 1'b1, 8'h28, 1'b0, 1'b0, 6};
      vecs[2] = '{8'hB8, 8'h30, 1'b0, 8'hB0, 1'b0, 1'b0, 5};
      vecs[3] = '{8'h38, 8'h18, 1'b0, 8'h38, 1'b0, 1'b0, 4};
      vecs[4] = '{8'h39, 8'h18, 1'b0, 8'h3A, 1'b0, 1'b0, 4};
      vecs[5] = '{8'h3C, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 4};
      vecs[6] = '{8'h00, 8'hB8, 1'b0, 8'hB8, 1'b0, 1'b0, 4};
      vecs[7] = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0, 5};
      vecs[8] = '{8'h09, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 7};

      // Reset, with start held high to show clear overrides it
      clear     = 1'b1;
      bus.start = 1'b1;
      bus.alpha = 8'h38;
      bus.beta  = 8'h38;
      bus.op    = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      clear     = 1'b0;
      bus.start = 1'b0;
      #1;
      check("reset_ready", 32'(bus.ready), 32'd1);
      check("reset_valid", 32'(bus.valid), 32'd0);
      check("reset_result", 32'(bus.result), 32'd0);
      check("reset_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
      idle_state = dbg_state;

      // Directed vectors, back to back (each later start is taken in DONE)
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, res, ovf, unf, lat);
         check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
         check($sformatf("vec%0d_flags", i), {30'd0, ovf, unf}, {30'd0, vecs[i].ovf, vecs[i].unf});
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Leave a nonzero result, then clear while the next op is normalising
      run_op(8'h38, 8'h38, 1'b0, res, ovf, unf, lat);
      check("pre_clear_result", 32'(res), 32'h40);
      @(negedge clock);
      bus.start = 1'b1;
      bus.alpha = 8'h3C;
      bus.beta  = 8'h3A;
      bus.op    = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      check("clear_ready", 32'(bus.ready), 32'd1);
      check("clear_valid", 32'(bus.valid), 32'd0);
      check("clear_result", 32'(bus.result), 32'd0);
      check("clear_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
      check("clear_state_as_reset", 32'(dbg_state), 32'(idle_state));
      repeat (6) @(posedge clock);
      #1;
      check("clear_no_completion", 32'(bus.valid), 32'd0);

      // start held high while busy, operands changing: only the first is taken
      @(negedge clock);
      bus.start = 1'b1;
      bus.alpha = 8'h38;
      bus.beta  = 8'h38;
      bus.op    = 1'b0;
      @(posedge clock);
      #1;
      bus.alpha = 8'h3C;
      bus.beta  = 8'h3A;
      bus.op    = 1'b1;
      lat = 0;
      while (!bus.valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      bus.start = 1'b0;
      check("busy_start_result", 32'(bus.result), 32'h40);
      check("busy_start_latency", 32'(lat), 32'd5);

      // Random operands against the reference model
      for (int n = 0; n < 300; n++) begin
         logic [W-1:0] ra, rb;
         logic         rop;
         ra  = $urandom_range(0, 255);
         rb  = $urandom_range(0, 255);
         rop = $urandom_range(0, 1);
         if (n % 4 == 0) rb = {rb[7], ra[6:3] - 4'($urandom_range(0, 1)), rb[2:0]};
         exp_q.push_back(model(ra, rb, rop));
         run_op(ra, rb, rop, res, ovf, unf, lat);
         e = exp_q.pop_front();
         if ({ovf, unf, res} !== e)
            $display("  operands a=0x%0h b=0x%0h op=%0d", ra, rb, rop);
         check("rand_result_flags", {22'd0, ovf, unf, res}, {22'd0, e});
         check("rand_latency_range", 32'((lat >= 4) && (lat <= 10)), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
